// File: rtl/filtros_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : filtros_pkg                                                    |
// | Purpose  : Shared definitions for the filter datapath: extremum mode     |
// |            encodings and a constant-evaluable ceil(log2) helper.         |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package filtros_pkg;

   localparam logic MODO_MAX = 1'b0;
   localparam logic MODO_MIN = 1'b1;

   // ceil(log2(valor)); returns 0 for valor <= 1. Usable in parameter context.
   function automatic int clog2(input int valor);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < valor) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/comparador_extremo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : comparador_extremo                                            |
// | Purpose  : Combinational two-input extremum select. One operand is      |
// |            always the newer sample; on equal values the newer operand   |
// |            wins, so ties resolve deterministically.                     |
// | Ports    : modo_i        0 = max, 1 = min                                |
// |            nuevo_i       value of the newer operand                      |
// |            viejo_i       value of the older operand                      |
// |            idx_nuevo_i   index of the newer operand (FILTRO_INDICE_EN)   |
// |            idx_viejo_i   index of the older operand (FILTRO_INDICE_EN)   |
// |            valor_o       selected value                                  |
// |            idx_o         index of selected value (FILTRO_INDICE_EN)      |
// | Config   : FILTRO_INDICE_EN adds the index ports and the index mux.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module comparador_extremo
   import filtros_pkg::*;
#(
   parameter int BITS_NUMERO = 8,
   parameter bit CON_SIGNO   = 1'b0
`ifdef FILTRO_INDICE_EN
   ,
   parameter int BITS_INDICE = 3
`endif
) (
   input  logic                   modo_i,
   input  logic [BITS_NUMERO-1:0] nuevo_i,
   input  logic [BITS_NUMERO-1:0] viejo_i,
`ifdef FILTRO_INDICE_EN
   input  logic [BITS_INDICE-1:0] idx_nuevo_i,
   input  logic [BITS_INDICE-1:0] idx_viejo_i,
   output logic [BITS_INDICE-1:0] idx_o,
`endif
   output logic [BITS_NUMERO-1:0] valor_o
);

   logic w_viejo_mayor;
   logic w_viejo_menor;
   logic w_elegir_viejo;

   // Strict comparisons: the older operand is chosen only when it is
   // strictly better, which is what makes ties go to the newer sample.
   generate
      if (CON_SIGNO) begin : g_con_signo
         assign w_viejo_mayor = $signed(viejo_i) > $signed(nuevo_i);
         assign w_viejo_menor = $signed(viejo_i) < $signed(nuevo_i);
      end else begin : g_sin_signo
         assign w_viejo_mayor = viejo_i > nuevo_i;
         assign w_viejo_menor = viejo_i < nuevo_i;
      end
   endgenerate

   assign w_elegir_viejo = (modo_i == MODO_MIN) ? w_viejo_menor : w_viejo_mayor;
   assign valor_o        = w_elegir_viejo ? viejo_i : nuevo_i;

`ifdef FILTRO_INDICE_EN
   assign idx_o = w_elegir_viejo ? idx_viejo_i : idx_nuevo_i;
`endif

endmodule
`default_nettype wire

// File: rtl/filtro_extremo_ventana.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : filtro_extremo_ventana                                        |
// | Purpose  : Streaming sliding-window extremum (max/min) filter over the   |
// |            last VENTANA accepted samples, valid/ready on both sides,    |
// |            synchronous window flush, 1-cycle accept-to-result latency.  |
// | Ports    : clk, rst_n (sync, active low)                                 |
// |            entrada/entrada_valida/entrada_lista  input stream            |
// |            modo     0 = max, 1 = min, taken with each accepted sample    |
// |            limpiar  one-cycle window flush, wins over accept             |
// |            salida/salida_valida/salida_lista     result stream           |
// |            indice   position of extremum, 0 = newest (FILTRO_INDICE_EN)  |
// | Params   : BITS_NUMERO sample width, VENTANA depth (2..64),             |
// |            CON_SIGNO 0 = unsigned, 1 = two's-complement compare         |
// | Config   : FILTRO_INDICE_EN enables the indice output and index logic.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module filtro_extremo_ventana
   import filtros_pkg::*;
#(
   parameter int BITS_NUMERO = 8,
   parameter int VENTANA     = 5,
   parameter bit CON_SIGNO   = 1'b0,
   localparam int BITS_INDICE = clog2(VENTANA)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [BITS_NUMERO-1:0] entrada,
   input  logic                   entrada_valida,
   output logic                   entrada_lista,
   input  logic                   modo,
   input  logic                   limpiar,
   output logic [BITS_NUMERO-1:0] salida,
   output logic                   salida_valida,
   input  logic                   salida_lista
`ifdef FILTRO_INDICE_EN
   ,
   output logic [BITS_INDICE-1:0] indice
`endif
);

   localparam int                 BITS_CUENTA = clog2(VENTANA + 1);
   localparam logic [BITS_CUENTA-1:0] CUENTA_LLENA = BITS_CUENTA'(VENTANA);

   // Only VENTANA-1 samples are stored: the slot that would be oldest is
   // exactly the one dropped on the next accept, and the result is always
   // computed over the window including the incoming sample.
   logic [BITS_NUMERO-1:0] ventana_q [VENTANA-1];
   logic [BITS_NUMERO-1:0] ventana_d [VENTANA];
   logic [BITS_CUENTA-1:0] cuenta_q;
   logic [BITS_CUENTA-1:0] cuenta_d;
   logic [BITS_NUMERO-1:0] salida_q;
   logic                   salida_valida_q;
   logic                   w_acepta;

   // w_acc[k] = extremum over slots k..VENTANA-1 of the shifted window
   logic [BITS_NUMERO-1:0] w_acc [VENTANA];
`ifdef FILTRO_INDICE_EN
   logic [BITS_INDICE-1:0] w_idx [VENTANA];
   logic [BITS_INDICE-1:0] indice_q;
`endif

   assign entrada_lista = !limpiar && (!salida_valida_q || salida_lista);
   assign w_acepta      = entrada_valida && entrada_lista;

   always_comb begin
      ventana_d[0] = entrada;
      for (int i = 1; i < VENTANA; i++) begin
         ventana_d[i] = ventana_q[i-1];
      end
   end

   assign cuenta_d = (cuenta_q == CUENTA_LLENA) ? cuenta_q : cuenta_q + 1'b1;

   // Reduction of VENTANA-1 comparator nodes running from the oldest slot
   // towards the newest; each node's "nuevo" operand is a strictly newer
   // slot than anything folded into its "viejo" operand.
   assign w_acc[VENTANA-1] = ventana_d[VENTANA-1];
`ifdef FILTRO_INDICE_EN
   assign w_idx[VENTANA-1] = BITS_INDICE'(VENTANA - 1);
`endif

   generate
      for (genvar k = 0; k < VENTANA - 1; k++) begin : g_nodo
         comparador_extremo #(
            .BITS_NUMERO (BITS_NUMERO),
            .CON_SIGNO   (CON_SIGNO)
`ifdef FILTRO_INDICE_EN
            ,
            .BITS_INDICE (BITS_INDICE)
`endif
         ) u_comparador (
            .modo_i      (modo),
            .nuevo_i     (ventana_d[k]),
            .viejo_i     (w_acc[k+1]),
`ifdef FILTRO_INDICE_EN
            .idx_nuevo_i (BITS_INDICE'(k)),
            .idx_viejo_i (w_idx[k+1]),
            .idx_o       (w_idx[k]),
`endif
            .valor_o     (w_acc[k])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < VENTANA - 1; i++) begin
            ventana_q[i] <= '0;
         end
         cuenta_q        <= '0;
         salida_q        <= '0;
         salida_valida_q <= 1'b0;
`ifdef FILTRO_INDICE_EN
         indice_q        <= '0;
`endif
      end else if (limpiar) begin
         // Stale window contents stay in place; the zeroed counter masks them.
         cuenta_q        <= '0;
         salida_valida_q <= 1'b0;
      end else begin
         if (w_acepta) begin
            for (int i = 0; i < VENTANA - 1; i++) begin
               ventana_q[i] <= ventana_d[i];
            end
            cuenta_q <= cuenta_d;
         end
         if (w_acepta && (cuenta_d == CUENTA_LLENA)) begin
            salida_q        <= w_acc[0];
            salida_valida_q <= 1'b1;
`ifdef FILTRO_INDICE_EN
            indice_q        <= w_idx[0];
`endif
         end else if (salida_lista) begin
            salida_valida_q <= 1'b0;
         end
      end
   end

   assign salida        = salida_q;
   assign salida_valida = salida_valida_q;
`ifdef FILTRO_INDICE_EN
   assign indice        = indice_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_filtro_extremo_ventana.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_filtro_extremo_ventana                                     |
// | Purpose  : Self-checking bench for filtro_extremo_ventana. Two DUTs      |
// |            (unsigned and signed compare) share one input stream; a      |
// |            queue-based golden model predicts every delivered result.    |
// | Config   : FILTRO_INDICE_EN also checks the indice output.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_filtro_extremo_ventana;

   localparam int BITS = 8;
   localparam int VENT = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [BITS-1:0] entrada = '0;
   logic            entrada_valida = 1'b0;
   logic            modo = 1'b0;
   logic            limpiar = 1'b0;
   logic            salida_lista = 1'b1;

   logic            lista_u, lista_s;
   logic [BITS-1:0] salida_u, salida_s;
   logic            valida_u, valida_s;
`ifdef FILTRO_INDICE_EN
   logic [2:0]      idx_u, idx_s;
`endif

   always #5 clk = ~clk;

   filtro_extremo_ventana #(.BITS_NUMERO(BITS), .VENTANA(VENT), .CON_SIGNO(1'b0)) dut_u (
      .clk            (clk),
      .rst_n          (rst_n),
      .entrada        (entrada),
      .entrada_valida (entrada_valida),
      .entrada_lista  (lista_u),
      .modo           (modo),
      .limpiar        (limpiar),
      .salida         (salida_u),
      .salida_valida  (valida_u),
      .salida_lista   (salida_lista)
`ifdef FILTRO_INDICE_EN
      ,
      .indice         (idx_u)
`endif
   );

   filtro_extremo_ventana #(.BITS_NUMERO(BITS), .VENTANA(VENT), .CON_SIGNO(1'b1)) dut_s (
      .clk            (clk),
      .rst_n          (rst_n),
      .entrada        (entrada),
      .entrada_valida (entrada_valida),
      .entrada_lista  (lista_s),
      .modo           (modo),
      .limpiar        (limpiar),
      .salida         (salida_s),
      .salida_valida  (valida_s),
      .salida_lista   (salida_lista)
`ifdef FILTRO_INDICE_EN
      ,
      .indice         (idx_s)
`endif
   );

   typedef struct {
      logic [BITS-1:0] u;
      logic [BITS-1:0] s;
      int              iu;
      int              is_;
   } esperado_t;

   esperado_t       cola[$];
   logic [BITS-1:0] modelo[$];   // front = newest sample
   int              checks = 0;
   int              errors = 0;

   // a strictly better than b under the given compare
   function automatic bit mejor(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                input bit cs, input bit m);
      int ia, ib;
      ia = cs ? int'($signed(a)) : int'(a);
      ib = cs ? int'($signed(b)) : int'(b);
      return m ? (ia < ib) : (ia > ib);
   endfunction

   function automatic void extremo(input bit cs, input bit m,
                                   output logic [BITS-1:0] v, output int idx);
      v   = modelo[0];
      idx = 0;
      for (int i = 1; i < modelo.size(); i++) begin
         if (mejor(modelo[i], v, cs, m)) begin
            v   = modelo[i];
            idx = i;
         end
      end
   endfunction

   // Scoreboard: observes both handshakes half a cycle before the edge that
   // acts on them. Pop/compare the result being consumed, then predict.
   always @(negedge clk) begin
      esperado_t e;
      if (!rst_n || limpiar) begin
         cola.delete();
         modelo.delete();
      end else begin
         if (valida_u && salida_lista) begin
            checks++;
            if (cola.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: salida_u=%h valid with nothing expected", salida_u);
            end else begin
               e = cola.pop_front();
               if (salida_u !== e.u || salida_s !== e.s || valida_s !== 1'b1) begin
                  errors++;
                  $display("FAIL sb_salida: got u=%h s=%h vs=%b, expected u=%h s=%h vs=1",
                           salida_u, salida_s, valida_s, e.u, e.s);
               end
`ifdef FILTRO_INDICE_EN
               if (int'(idx_u) != e.iu || int'(idx_s) != e.is_) begin
                  errors++;
                  $display("FAIL sb_indice: got u=%0d s=%0d, expected u=%0d s=%0d",
                           idx_u, idx_s, e.iu, e.is_);
               end
`endif
            end
         end
         if (entrada_valida && lista_u) begin
            modelo.push_front(entrada);
            if (modelo.size() > VENT) void'(modelo.pop_back());
            if (modelo.size() == VENT) begin
               extremo(1'b0, modo, e.u, e.iu);
               extremo(1'b1, modo, e.s, e.is_);
               cola.push_back(e);
            end
         end
      end
   end

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic send(input logic [BITS-1:0] v, input logic m);
      int espera;
      entrada        = v;
      modo           = m;
      entrada_valida = 1'b1;
      espera         = 0;
      @(negedge clk);
      while (!lista_u && espera < 100) begin
         @(negedge clk);
         espera++;
      end
      if (!lista_u) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: entrada_lista=%b, required 1", lista_u);
      end
      @(posedge clk); #1;
      entrada_valida = 1'b0;
   endtask

   task automatic flush();
      limpiar = 1'b1;
      @(posedge clk); #1;
      limpiar = 1'b0;
   endtask

   task automatic drain();
      salida_lista = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cola.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results still expected, required 0", cola.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (salida_u !== 8'h00 || valida_u !== 1'b0 || salida_s !== 8'h00 || valida_s !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: salida=%h/%h valida=%b/%b, required 00/00 0/0",
                  salida_u, salida_s, valida_u, valida_s);
      end
      checks++;
      if (lista_u !== 1'b1) begin
         errors++;
         $display("FAIL reset_lista: entrada_lista=%b, required 1", lista_u);
      end
`ifdef FILTRO_INDICE_EN
      checks++;
      if (idx_u !== 3'd0) begin
         errors++;
         $display("FAIL reset_indice: indice=%0d, required 0", idx_u);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_basic_max();
      logic [BITS-1:0] vals [5] = '{8'd3, 8'd9, 8'd1, 8'd4, 8'd2};
      flush();
      salida_lista = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(vals[i], 1'b0);
         checks++;
         if (valida_u !== (i == 4)) begin
            errors++;
            $display("FAIL basic_fill%0d: salida_valida=%b, required %0d", i, valida_u, (i == 4));
         end
      end
      checks++;
      if (salida_u !== 8'd9) begin
         errors++;
         $display("FAIL basic_first: salida=%0d, required 9", salida_u);
      end
`ifdef FILTRO_INDICE_EN
      checks++;
      if (idx_u !== 3'd3) begin
         errors++;
         $display("FAIL basic_first_idx: indice=%0d, required 3", idx_u);
      end
`endif
      send(8'd0, 1'b0);
      checks++;
      if (salida_u !== 8'd9) begin
         errors++;
         $display("FAIL basic_second: salida=%0d, required 9", salida_u);
      end
`ifdef FILTRO_INDICE_EN
      checks++;
      if (idx_u !== 3'd4) begin
         errors++;
         $display("FAIL basic_second_idx: indice=%0d, required 4", idx_u);
      end
`endif
      send(8'd0, 1'b0);
      checks++;
      if (salida_u !== 8'd4) begin
         errors++;
         $display("FAIL basic_third: salida=%0d, required 4", salida_u);
      end
      drain();
   endtask

   task automatic test_signed_min();
      flush();
      send(8'hFF, 1'b1);
      repeat (4) send(8'h01, 1'b1);
      checks++;
      if (salida_s !== 8'hFF || salida_u !== 8'h01) begin
         errors++;
         $display("FAIL signed_min: signed=%h unsigned=%h, required FF 01", salida_s, salida_u);
      end
      drain();
   endtask

   task automatic test_ties();
      flush();
      repeat (5) send(8'd5, 1'b0);
      checks++;
      if (salida_u !== 8'd5) begin
         errors++;
         $display("FAIL ties_max: salida=%0d, required 5", salida_u);
      end
`ifdef FILTRO_INDICE_EN
      checks++;
      if (idx_u !== 3'd0) begin
         errors++;
         $display("FAIL ties_max_idx: indice=%0d, required 0", idx_u);
      end
`endif
      send(8'd5, 1'b1);
      checks++;
      if (salida_u !== 8'd5) begin
         errors++;
         $display("FAIL ties_min: salida=%0d, required 5", salida_u);
      end
`ifdef FILTRO_INDICE_EN
      checks++;
      if (idx_u !== 3'd0) begin
         errors++;
         $display("FAIL ties_min_idx: indice=%0d, required 0", idx_u);
      end
`endif
      drain();
   endtask

   task automatic test_backpressure();
      logic [BITS-1:0] vals [5] = '{8'd10, 8'd40, 8'd20, 8'd30, 8'd50};
      logic [BITS-1:0] held;
      flush();
      salida_lista = 1'b0;
      for (int i = 0; i < 5; i++) send(vals[i], 1'b0);
      held           = salida_u;
      entrada        = 8'h77;
      modo           = 1'b0;
      entrada_valida = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (lista_u !== 1'b0 || valida_u !== 1'b1 || salida_u !== held || held !== 8'd50) begin
            errors++;
            $display("FAIL stall_c%0d: lista=%b valida=%b salida=%h, required 0 1 32",
                     c, lista_u, valida_u, salida_u);
         end
      end
      @(posedge clk); #1;
      salida_lista = 1'b1;
      @(negedge clk);
      checks++;
      if (lista_u !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: entrada_lista=%b, required 1", lista_u);
      end
      @(posedge clk); #1;
      entrada_valida = 1'b0;
      checks++;
      if (salida_u !== 8'h77 || valida_u !== 1'b1) begin
         errors++;
         $display("FAIL stall_after: salida=%h valida=%b, required 77 1", salida_u, valida_u);
      end
      fork
         begin
            for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         end
         begin
            repeat (60) begin
               salida_lista = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            salida_lista = 1'b1;
         end
      join
      drain();
   endtask

   task automatic test_back_to_back();
      flush();
      salida_lista = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         if (i >= 4) begin
            checks++;
            if (valida_u !== 1'b1) begin
               errors++;
               $display("FAIL b2b_valid%0d: salida_valida=%b, required 1", i, valida_u);
            end
         end
      end
      drain();
   endtask

   task automatic test_flush();
      flush();
      salida_lista = 1'b1;
      send(8'd10, 1'b0);
      send(8'd20, 1'b0);
      send(8'd30, 1'b0);
      limpiar        = 1'b1;
      entrada        = 8'hAA;
      entrada_valida = 1'b1;
      @(negedge clk);
      checks++;
      if (lista_u !== 1'b0) begin
         errors++;
         $display("FAIL flush_lista: entrada_lista=%b, required 0", lista_u);
      end
      @(posedge clk); #1;
      limpiar        = 1'b0;
      entrada_valida = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send(8'(i), 1'b0);
         checks++;
         if (valida_u !== (i == 5)) begin
            errors++;
            $display("FAIL flush_refill%0d: salida_valida=%b, required %0d", i, valida_u, (i == 5));
         end
      end
      checks++;
      if (salida_u !== 8'd5) begin
         errors++;
         $display("FAIL flush_value: salida=%0d, required 5", salida_u);
      end
      drain();
   endtask

   task automatic test_reset_midstream();
      logic [BITS-1:0] vals [5] = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd2};
      flush();
      salida_lista = 1'b0;
      for (int i = 0; i < 5; i++) send(8'd100 + 8'(i), 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (salida_u !== 8'h00 || valida_u !== 1'b0 || salida_s !== 8'h00) begin
         errors++;
         $display("FAIL midreset: salida=%h valida=%b salida_s=%h, required 00 0 00",
                  salida_u, valida_u, salida_s);
      end
      rst_n        = 1'b1;
      salida_lista = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(vals[i], 1'b0);
         checks++;
         if (valida_u !== (i == 4)) begin
            errors++;
            $display("FAIL midreset_refill%0d: salida_valida=%b, required %0d", i, valida_u, (i == 4));
         end
      end
      checks++;
      if (salida_u !== 8'd9) begin
         errors++;
         $display("FAIL midreset_value: salida=%0d, required 9", salida_u);
      end
      drain();
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_basic_max();
      test_signed_min();
      test_ties();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
